// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline (fixed priority) and a DMA port with starvation-forced DMA grants.
// Latency: 1 cycle from acceptance to rsp_valid; backpressure: combinational per-port ready, at most one high, p_stall = p_req_valid & ~p_req_ready.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req_valid,
  input  logic              p_req_write,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_req_ready,
  output logic              p_stall,
  output logic              p_rsp_valid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req_valid,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    P_PRI   = 1'b0,
    D_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       p_gnt;
  logic       d_gnt;

  always_comb begin
    p_gnt = p_req_valid & ~((state == D_FORCE) & d_req_valid);
    d_gnt = d_req_valid & ~p_gnt;
  end

  assign p_req_ready = p_gnt;
  assign d_req_ready = d_gnt;
  assign p_stall     = p_req_valid & ~p_gnt;

  // Memory pins are driven straight from the winning port; idle parks everything at zero.
  always_comb begin
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    if (p_gnt) begin
      mem_addr     = p_addr;
      mem_wdata    = p_wdata;
      mem_write_en = p_req_write;
      mem_read_en  = ~p_req_write;
    end else if (d_gnt) begin
      mem_addr     = d_addr;
      mem_wdata    = d_wdata;
      mem_write_en = d_req_write;
      mem_read_en  = ~d_req_write;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (d_gnt || !d_req_valid) begin
      starve_nxt = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= P_PRI;
      starve_cnt  <= '0;
      p_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      p_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      starve_cnt  <= starve_nxt;
      p_rsp_valid <= p_gnt;
      d_rsp_valid <= d_gnt;
      if (p_gnt) p_rdata <= p_req_write ? '0 : mem_rdata;
      if (d_gnt) d_rdata <= d_req_write ? '0 : mem_rdata;
      case (state)
        P_PRI:   if (starve_nxt == LIMIT) state <= D_FORCE;
        D_FORCE: if (d_gnt || !d_req_valid) state <= P_PRI;
        default: state <= P_PRI;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory model attached to the mem_* pins.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p_req_valid, p_req_write;
  logic [7:0] p_addr, p_wdata;
  logic       p_req_ready, p_stall, p_rsp_valid;
  logic [7:0] p_rdata;
  logic       d_req_valid, d_req_write;
  logic [7:0] d_addr, d_wdata;
  logic       d_req_ready, d_rsp_valid;
  logic [7:0] d_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_write_en, mem_read_en;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req_valid(p_req_valid), .p_req_write(p_req_write), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_req_ready(p_req_ready), .p_stall(p_stall), .p_rsp_valid(p_rsp_valid), .p_rdata(p_rdata),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_req_valid = 1'b0; p_req_write = 1'b0; p_addr = 8'h00; p_wdata = 8'h00;
    d_req_valid = 1'b0; d_req_write = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
  endtask

  task automatic p_set(input logic wr, input logic [7:0] a, input logic [7:0] wd);
    p_req_valid = 1'b1; p_req_write = wr; p_addr = a; p_wdata = wd;
  endtask

  task automatic d_set(input logic wr, input logic [7:0] a, input logic [7:0] wd);
    d_req_valid = 1'b1; d_req_write = wr; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h33;
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_p_rsp_valid", 32'(p_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_p_rdata", 32'(p_rdata), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_mem_en", 32'({mem_write_en, mem_read_en}), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Pipeline read of 0x10
    p_set(1'b0, 8'h10, 8'h00);
    #1;
    chk("t1_p_ready", 32'(p_req_ready), 32'd1);
    chk("t1_d_ready", 32'(d_req_ready), 32'd0);
    chk("t1_read_en", 32'(mem_read_en), 32'd1);
    chk("t1_write_en", 32'(mem_write_en), 32'd0);
    chk("t1_mem_addr", 32'(mem_addr), 32'h10);
    cyc();
    idle();
    chk("t1_p_rsp_valid", 32'(p_rsp_valid), 32'd1);
    chk("t1_p_rdata", 32'(p_rdata), 32'hA5);
    chk("t1_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("t1_d_rdata", 32'(d_rdata), 32'd0);
    cyc();
    chk("t1_p_rsp_one_cycle", 32'(p_rsp_valid), 32'd0);
    chk("t1_p_rdata_hold", 32'(p_rdata), 32'hA5);

    // DMA write of 0x33 to 0x20, then pipeline reads it back
    d_set(1'b1, 8'h20, 8'h33);
    #1;
    chk("t2_d_ready", 32'(d_req_ready), 32'd1);
    chk("t2_write_en", 32'(mem_write_en), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h20);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'h33);
    cyc();
    idle();
    chk("t2_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("t2_d_rdata", 32'(d_rdata), 32'd0);
    p_set(1'b0, 8'h20, 8'h00);
    cyc();
    idle();
    chk("t2_p_readback", 32'(p_rdata), 32'h33);
    chk("t2_p_rsp_valid", 32'(p_rsp_valid), 32'd1);
    cyc();

    // Continuous contention: DMA forced through on the fifth cycle
    p_set(1'b0, 8'h01, 8'h00);
    d_set(1'b0, 8'h02, 8'h00);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_p_ready_%0d", k), 32'(p_req_ready), (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("t3_d_ready_%0d", k), 32'(d_req_ready), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_p_stall_%0d", k), 32'(p_stall), (k == 4) ? 32'd1 : 32'd0);
      cyc();
      chk($sformatf("t3_d_rsp_%0d", k), 32'(d_rsp_valid), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_p_rsp_%0d", k), 32'(p_rsp_valid), (k == 4) ? 32'd0 : 32'd1);
      if (k == 4) chk("t3_d_rdata", 32'(d_rdata), 32'h22);
    end
    idle();
    cyc();
    chk("t3_starve_clear", 32'(dut.starve_cnt), 32'd0);
    chk("t3_state", 32'(dut.state), 32'd0);

    // One-cycle simultaneous request: pipeline first, DMA next
    p_set(1'b0, 8'h03, 8'h00);
    d_set(1'b0, 8'h01, 8'h00);
    #1;
    chk("t4_p_ready", 32'(p_req_ready), 32'd1);
    chk("t4_d_ready", 32'(d_req_ready), 32'd0);
    cyc();
    p_req_valid = 1'b0;
    chk("t4_p_rdata", 32'(p_rdata), 32'h33);
    chk("t4_starve_one", 32'(dut.starve_cnt), 32'd1);
    #1;
    chk("t4_d_ready_next", 32'(d_req_ready), 32'd1);
    cyc();
    idle();
    chk("t4_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("t4_d_rdata", 32'(d_rdata), 32'h11);
    chk("t4_starve_zero", 32'(dut.starve_cnt), 32'd0);
    cyc();

    // Reset pulse between acceptance and the capturing edge
    p_set(1'b0, 8'h10, 8'h00);
    #1;
    chk("t5_p_ready", 32'(p_req_ready), 32'd1);
    #1;
    rst_n = 1'b0;
    #5;
    idle();
    rst_n = 1'b1;
    cyc();
    chk("t5_p_rsp_dropped", 32'(p_rsp_valid), 32'd0);
    chk("t5_p_rdata_clr", 32'(p_rdata), 32'd0);
    chk("t5_starve", 32'(dut.starve_cnt), 32'd0);
    chk("t5_state", 32'(dut.state), 32'd0);
    cyc();
    chk("t5_p_rsp_still0", 32'(p_rsp_valid), 32'd0);

    // Back-to-back pipeline reads
    for (int i = 1; i <= 3; i++) begin
      p_set(1'b0, 8'(i), 8'h00);
      #1;
      chk($sformatf("t6_p_stall_%0d", i), 32'(p_stall), 32'd0);
      cyc();
      chk($sformatf("t6_p_rsp_%0d", i), 32'(p_rsp_valid), 32'd1);
      chk($sformatf("t6_p_rdata_%0d", i), 32'(p_rdata), 32'(8'h11 * i));
    end
    idle();
    cyc();
    chk("t6_p_rsp_end", 32'(p_rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory between the pipeline MEM stage and a DMA/loader port. The pipeline has fixed priority, bounded by a starvation counter that forces a DMA grant after STARVE_LIMIT consecutive denied cycles. The block drives the memory's address, write-data, write-enable and read-enable pins directly. It returns a registered response to the requester that was granted. The pipeline uses p_stall to freeze the EX/MEM latch.

Parameters:
ADDR_W, 8, address width (matches data memory)
DATA_W, 8, data width
STARVE_LIMIT, 4, consecutive denied DMA cycles before a forced DMA grant; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
p_req_valid  in  1  pipeline request present
p_req_write  in  1  1=write, 0=read
p_addr  in  ADDR_W  pipeline address
p_wdata  in  DATA_W  pipeline write data
p_req_ready  out  1  pipeline request accepted this cycle
p_stall  out  1  p_req_valid & ~p_req_ready
p_rsp_valid  out  1  pipeline response valid
p_rdata  out  DATA_W  pipeline read data
d_req_valid, d_req_write, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA request, same meaning as p_*
d_req_ready  out  1  DMA request accepted this cycle
d_rsp_valid  out  1  DMA response valid
d_rdata  out  DATA_W  DMA read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_write_en  out  1  memory write enable
mem_read_en  out  1  memory read enable
mem_rdata  in  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- Reset (rst_n low, asynchronous): starve_cnt=0, state=P_PRI, *_rsp_valid=0, *_rdata=0. Combinational outputs follow from the cleared state.
- Handshake:
  - A request is accepted when valid & ready.
  - A requester holds valid and its payload stable until accepted.
  - Ready is combinational from both valids and the state; at most one ready is high per cycle.
- Grant rule:
  - p granted if p_req_valid & ~(state==D_FORCE & d_req_valid).
  - Otherwise d granted if d_req_valid.
  - Otherwise idle.
- Memory drive:
  - In the grant cycle, mem_addr and mem_wdata come from the granted port.
  - mem_write_en = granted & write; mem_read_en = granted & ~write.
  - When idle: all memory enables 0, mem_addr/mem_wdata = 0.
- Response timing (latency 1):
  - The cycle after acceptance, the granted port's rsp_valid=1 for exactly one cycle, for both reads and writes.
  - rdata = mem_rdata registered in the grant cycle for a read; 0 for a write.
  - rdata holds its value until the next response for that port.
- Back-to-back acceptances are allowed every cycle. Responses follow in acceptance order, one per cycle.
- starve_cnt:
  - Clears if d granted or ~d_req_valid.
  - Otherwise increments when d_req_valid & ~d_req_ready, saturating at STARVE_LIMIT.
- FSM:
  - P_PRI -> D_FORCE when the next starve_cnt == STARVE_LIMIT.
  - D_FORCE -> P_PRI on a d grant, or when d_req_valid drops.
  - In D_FORCE, the pipeline is denied (p_stall=1) while d_req_valid is high.
- Simultaneous requests in P_PRI: pipeline wins and starve_cnt increments.
- Reset asserted mid-transaction: any pending response is dropped; no rsp_valid after release.
- Same-address write/read in consecutive cycles is serialized by the memory, so the read returns the new data.

Test Plan:
- Reset, then p read addr 0x10 with mem[0x10]=0xA5 -> p_req_ready=1 in the same cycle, mem_read_en=1; next cycle p_rsp_valid=1, p_rdata=0xA5; d_* outputs stay 0.
- d write 0x33 to addr 0x20 with p idle -> d_req_ready=1, mem_write_en=1, mem_addr=0x20; next cycle d_rsp_valid=1, d_rdata=0; a later p read of 0x20 returns 0x33.
- p and d valid continuously, STARVE_LIMIT=4 -> p granted for cycles 0-3, p_stall=1 in cycle 4, d granted in cycle 4, p granted again in cycle 5.
- p and d valid simultaneously for one cycle only -> p granted; d granted the next cycle; starve_cnt returns to 0.
- Pipeline read accepted, then rst_n pulsed low for half a cycle before the next edge -> p_rsp_valid stays 0, starve_cnt=0, state=P_PRI.
- p reads addresses 0x01, 0x02, 0x03 on consecutive cycles -> three consecutive p_rsp_valid pulses with the matching data in order; p_stall never asserted.
